// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the two-port data-memory arbiter.
// Only these defaults are sized by the package; the module re-derives widths from its own parameters.
package dmem_arb_pkg;

    localparam int DEF_NLOC     = 64;
    localparam int DEF_DBITS    = 32;
    localparam int DEF_MAXBURST = 4;
    localparam int DEF_AW       = $clog2(DEF_NLOC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } owner_t;

    // Request fields of one port at the default memory geometry.
    typedef struct packed {
        logic                 wr;
        logic [DEF_AW-1:0]    addr;
        logic [DEF_DBITS-1:0] din;
    } mem_req_t;

endpackage

// File: rtl/dmem_arb_resp.sv
// Read-return register for one requester: captures memory read data on a granted
// read and flags it valid for exactly the following cycle.
module dmem_arb_resp
    import dmem_arb_pkg::*;
#(
    parameter int Dbits = DEF_DBITS
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             gnt,
    input  logic             wr,
    input  logic [Dbits-1:0] mem_dout,
    output logic             rvalid,
    output logic [Dbits-1:0] dout
);

    // dout only moves on a granted read so the requester can sample it late.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rvalid <= 1'b0;
            dout   <= '0;
        end else begin
            rvalid <= gnt & ~wr;
            if (gnt && !wr) begin
                dout <= mem_dout;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between requester A and requester B, granting at
// most one access per cycle with bounded bursts and a registered one-cycle read return.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int Nloc     = DEF_NLOC,
    parameter int Dbits    = DEF_DBITS,
    parameter int MAXBURST = DEF_MAXBURST,
    localparam int AW      = $clog2(Nloc)
) (
    input  logic             clock,
    input  logic             reset_n,

    input  logic             a_req,
    input  logic             a_wr,
    input  logic [AW-1:0]    a_addr,
    input  logic [Dbits-1:0] a_din,
    output logic             a_gnt,
    output logic             a_rvalid,
    output logic [Dbits-1:0] a_dout,

    input  logic             b_req,
    input  logic             b_wr,
    input  logic [AW-1:0]    b_addr,
    input  logic [Dbits-1:0] b_din,
    output logic             b_gnt,
    output logic             b_rvalid,
    output logic [Dbits-1:0] b_dout,

    output logic             mem_wr,
    output logic [AW-1:0]    mem_addr,
    output logic [Dbits-1:0] mem_din,
    input  logic [Dbits-1:0] mem_dout
);

    localparam int            CW      = $clog2(MAXBURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXBURST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef struct packed {
        logic             wr;
        logic [AW-1:0]    addr;
        logic [Dbits-1:0] din;
    } req_t;

    owner_t        owner, owner_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          last_b, last_b_next;
    logic          grant_a, grant_b;
    req_t          win_fields;

    // last_b resets high so A wins the first tie after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner  <= IDLE;
            cnt    <= '0;
            last_b <= 1'b1;
        end else begin
            owner  <= owner_next;
            cnt    <= cnt_next;
            last_b <= last_b_next;
        end
    end

    always_comb begin
        grant_a     = 1'b0;
        grant_b     = 1'b0;
        owner_next  = owner;
        cnt_next    = cnt;
        last_b_next = last_b;

        case (owner)
            IDLE: begin
                if (a_req && b_req) begin
                    grant_a = last_b;
                    grant_b = ~last_b;
                end else begin
                    grant_a = a_req;
                    grant_b = b_req;
                end
            end
            OWN_A: begin
                if (a_req && (cnt < CNT_MAX || !b_req)) grant_a = 1'b1;
                else                                    grant_b = b_req;
            end
            OWN_B: begin
                if (b_req && (cnt < CNT_MAX || !a_req)) grant_b = 1'b1;
                else                                    grant_a = a_req;
            end
            default: begin
            end
        endcase

        // A grant to a non-owner (including from IDLE) opens a fresh tenure.
        if (grant_a) begin
            if (owner == OWN_A) begin
                cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
            end else begin
                owner_next  = OWN_A;
                cnt_next    = CNT_ONE;
                last_b_next = 1'b0;
            end
        end else if (grant_b) begin
            if (owner == OWN_B) begin
                cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
            end else begin
                owner_next  = OWN_B;
                cnt_next    = CNT_ONE;
                last_b_next = 1'b1;
            end
        end else begin
            owner_next = IDLE;
            cnt_next   = '0;
        end
    end

    assign a_gnt = grant_a & reset_n;
    assign b_gnt = grant_b & reset_n;

    assign win_fields = b_gnt ? {b_wr, b_addr, b_din} : {a_wr, a_addr, a_din};
    assign mem_wr     = win_fields.wr & (a_gnt | b_gnt);
    assign mem_addr   = win_fields.addr;
    assign mem_din    = win_fields.din;

    dmem_arb_resp #(.Dbits(Dbits)) u_resp_a (
        .clock    (clock),
        .reset_n  (reset_n),
        .gnt      (a_gnt),
        .wr       (a_wr),
        .mem_dout (mem_dout),
        .rvalid   (a_rvalid),
        .dout     (a_dout)
    );

    dmem_arb_resp #(.Dbits(Dbits)) u_resp_b (
        .clock    (clock),
        .reset_n  (reset_n),
        .gnt      (b_gnt),
        .wr       (b_wr),
        .mem_dout (mem_dout),
        .rvalid   (b_rvalid),
        .dout     (b_dout)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic, checked each
// cycle against a rule-level reference model with its own shadow memory.
module tb_dmem_arbiter;

    localparam int NLOC     = 64;
    localparam int DBITS    = 32;
    localparam int MAXBURST = 4;
    localparam int AW       = $clog2(NLOC);

    logic             clock;
    logic             reset_n;
    logic             aReqT, aWrT, bReqT, bWrT;
    logic [AW-1:0]    aAddrT, bAddrT;
    logic [DBITS-1:0] aDinT, bDinT;
    logic             a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DBITS-1:0] a_dout, b_dout;
    logic             mem_wr;
    logic [AW-1:0]    mem_addr;
    logic [DBITS-1:0] mem_din, mem_dout;

    logic [DBITS-1:0] dmem [NLOC];
    logic             memClear;

    logic [DBITS-1:0] shadow [NLOC];
    int               mOwner, mRun, mLast;
    logic             expAValid, expBValid;
    logic [DBITS-1:0] expADout, expBDout;
    int               curWinner, sawWinner;
    bit               aAuto, bAuto, randMode;
    int               passCount, checkCount;
    int               burstSeq [9] = '{1, 1, 1, 1, 2, 2, 2, 2, 1};

    dmem_arbiter #(.Nloc(NLOC), .Dbits(DBITS), .MAXBURST(MAXBURST)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .a_req    (aReqT),
        .a_wr     (aWrT),
        .a_addr   (aAddrT),
        .a_din    (aDinT),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_dout   (a_dout),
        .b_req    (bReqT),
        .b_wr     (bWrT),
        .b_addr   (bAddrT),
        .b_din    (bDinT),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_dout   (b_dout),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single-port memory the arbiter drives: synchronous write, asynchronous read.
    always @(posedge clock) begin
        if (memClear) begin
            for (int i = 0; i < NLOC; i++) dmem[i] <= '0;
        end else if (mem_wr) begin
            dmem[mem_addr] <= mem_din;
        end
    end
    assign mem_dout = dmem[mem_addr];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("[TB] %s comparison did not hold", tag);
        end
    endtask

    task automatic modelReset();
        mOwner    = 0;
        mRun      = 0;
        mLast     = 2;
        expAValid = 1'b0;
        expBValid = 1'b0;
        expADout  = '0;
        expBDout  = '0;
    endtask

    task automatic setReset(input logic v);
        reset_n = v;
        if (!v) modelReset();
    endtask

    task automatic issueA(input logic wr, input logic [AW-1:0] addr, input logic [31:0] din);
        aReqT = 1'b1; aWrT = wr; aAddrT = addr; aDinT = din;
    endtask

    task automatic issueB(input logic wr, input logic [AW-1:0] addr, input logic [31:0] din);
        bReqT = 1'b1; bWrT = wr; bAddrT = addr; bDinT = din;
    endtask

    task automatic newA();
        issueA(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
    endtask

    task automatic newB();
        issueB(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
    endtask

    // 0 = nobody, 1 = A, 2 = B; burst limit only matters when both sides want the memory.
    function automatic int predictWinner();
        if (!aReqT && !bReqT) return 0;
        if (aReqT && !bReqT)  return 1;
        if (bReqT && !aReqT)  return 2;
        if (mOwner == 0)      return (mLast == 1) ? 2 : 1;
        if (mRun < MAXBURST)  return mOwner;
        return 3 - mOwner;
    endfunction

    task automatic checkOutput();
        curWinner = reset_n ? predictWinner() : 0;
        sawWinner = a_gnt ? 1 : (b_gnt ? 2 : 0);
        checkVal("a_gnt", a_gnt, curWinner == 1);
        checkVal("b_gnt", b_gnt, curWinner == 2);
        checkVal("mem_wr", mem_wr, (curWinner == 1) ? aWrT : (curWinner == 2) ? bWrT : 1'b0);
        checkVal("mem_addr", mem_addr, (curWinner == 2) ? bAddrT : aAddrT);
        checkVal("mem_din", mem_din, (curWinner == 2) ? bDinT : aDinT);
        checkVal("a_rvalid", a_rvalid, expAValid);
        checkVal("a_dout", a_dout, expADout);
        checkVal("b_rvalid", b_rvalid, expBValid);
        checkVal("b_dout", b_dout, expBDout);
    endtask

    task automatic advanceModel();
        if (!reset_n) begin
            modelReset();
            return;
        end
        if (curWinner == 0) begin
            mOwner = 0;
            mRun   = 0;
        end else if (curWinner == mOwner) begin
            if (mRun < MAXBURST) mRun++;
        end else begin
            mOwner = curWinner;
            mRun   = 1;
            mLast  = curWinner;
        end
        expAValid = 1'b0;
        expBValid = 1'b0;
        if (curWinner == 1) begin
            if (aWrT) shadow[aAddrT] = aDinT;
            else begin
                expAValid = 1'b1;
                expADout  = shadow[aAddrT];
            end
            aReqT = 1'b0;
        end
        if (curWinner == 2) begin
            if (bWrT) shadow[bAddrT] = bDinT;
            else begin
                expBValid = 1'b1;
                expBDout  = shadow[bAddrT];
            end
            bReqT = 1'b0;
        end
    endtask

    task automatic applyStimulus();
        if (randMode) setReset($urandom_range(0, 49) != 0);
        if (!aReqT && (aAuto || (randMode && $urandom_range(0, 99) < 60))) newA();
        if (!bReqT && (bAuto || (randMode && $urandom_range(0, 99) < 60))) newB();
    endtask

    task automatic runCycle();
        @(negedge clock);
        checkOutput();
        @(posedge clock);
        #1;
        advanceModel();
        applyStimulus();
    endtask

    initial begin
        passCount = 0; checkCount = 0;
        aAuto = 0; bAuto = 0; randMode = 0;
        reset_n = 1'b1; memClear = 1'b0;
        aReqT = 0; aWrT = 0; aAddrT = '0; aDinT = '0;
        bReqT = 0; bWrT = 0; bAddrT = '0; bDinT = '0;
        for (int i = 0; i < NLOC; i++) shadow[i] = '0;
        modelReset();

        // Reset held with both ports requesting writes.
        #2;
        setReset(1'b0);
        memClear = 1'b1;
        issueA(1'b1, 6'd1, 32'hAAAA_0001);
        issueB(1'b1, 6'd2, 32'hBBBB_0002);
        @(posedge clock);
        #1;
        checkVal("rstAGnt", a_gnt, 0);
        checkVal("rstBGnt", b_gnt, 0);
        checkVal("rstMemWr", mem_wr, 0);
        checkVal("rstARvalid", a_rvalid, 0);
        checkVal("rstBRvalid", b_rvalid, 0);
        checkVal("rstADout", a_dout, 0);
        checkVal("rstBDout", b_dout, 0);
        memClear = 1'b0;

        // First tie after reset goes to A, then B.
        issueA(1'b0, 6'd10, 32'h0);
        issueB(1'b0, 6'd11, 32'h0);
        setReset(1'b1);
        runCycle();
        checkVal("firstTieA", sawWinner, 1);
        runCycle();
        checkVal("firstTieB", sawWinner, 2);

        // A alone: write then read back.
        issueA(1'b1, 6'd5, 32'hDEADBEEF);
        runCycle();
        checkVal("aWriteGnt", sawWinner, 1);
        issueA(1'b0, 6'd5, 32'h0);
        runCycle();
        checkVal("aReadGnt", sawWinner, 1);
        checkVal("aReadValid", a_rvalid, 1);
        checkVal("aReadData", a_dout, 32'hDEADBEEF);

        // B writes, A reads the same word the next cycle.
        issueB(1'b1, 6'd3, 32'h12345678);
        runCycle();
        checkVal("bWriteGnt", sawWinner, 2);
        issueA(1'b0, 6'd3, 32'h0);
        runCycle();
        checkVal("crossValid", a_rvalid, 1);
        checkVal("crossData", a_dout, 32'h12345678);

        // Continuous contention: bursts of MAXBURST alternate.
        setReset(1'b0);
        aAuto = 1; bAuto = 1;
        if (!aReqT) newA();
        if (!bReqT) newB();
        @(posedge clock);
        #1;
        setReset(1'b1);
        for (int i = 0; i < 9; i++) begin
            runCycle();
            checkVal("burstSeq", sawWinner, burstSeq[i]);
        end

        // Reset pulsed during B's second burst grant.
        setReset(1'b0);
        if (!aReqT) newA();
        if (!bReqT) newB();
        @(posedge clock);
        #1;
        setReset(1'b1);
        for (int i = 0; i < 5; i++) begin
            runCycle();
            checkVal("preRstSeq", sawWinner, burstSeq[i]);
        end
        @(negedge clock);
        checkOutput();
        checkVal("midBurstB", b_gnt, 1);
        #1;
        setReset(1'b0);
        #1;
        checkVal("rstDropA", a_gnt, 0);
        checkVal("rstDropB", b_gnt, 0);
        checkVal("rstDropWr", mem_wr, 0);
        @(posedge clock);
        #1;
        checkVal("rstNoValidA", a_rvalid, 0);
        checkVal("rstNoValidB", b_rvalid, 0);
        setReset(1'b1);
        runCycle();
        checkVal("postRstA", sawWinner, 1);

        // Random traffic with occasional resets.
        aAuto = 0; bAuto = 0; randMode = 1;
        repeat (400) runCycle();
        randMode = 0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
